// File: rtl/mem_arbiter.sv
// Byte-serial arbiter owning the RAM port: MEM loads/stores beat instruction fetches,
// each access is split into byte cycles and reassembled little-endian.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_abort,
   output logic                  if_done,
   output logic [31:0]           if_data,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [1:0]            mem_size,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]           mem_wdata,
   output logic                  mem_done,
   output logic [31:0]           mem_rdata,
   input  logic [7:0]            ram_din,
   output logic [7:0]            ram_dout,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic                  ram_wr
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   typedef enum logic {OWN_IF, OWN_MEM} owner_t;

   state_t                state;
   owner_t                owner;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [2:0]            len;
   logic [2:0]            cnt;
   logic [31:0]           wdata_q;
   logic [31:0]           rbuf;
   logic                  wr_q;

   logic [2:0]            edge_k;
   logic [2:0]            mem_len;
   logic [31:0]           rbuf_next;
   logic [7:0]            wbyte;
   logic [ADDR_WIDTH-1:0] next_addr;

   // cnt is cleared at the grant edge, so the edge being processed is E(cnt+1).
   assign edge_k    = cnt + 3'd1;
   assign next_addr = base_addr + ADDR_WIDTH'(edge_k);
   assign ram_wr    = wr_q & rdy;

   always_comb begin
      mem_len = 3'd4;
      case (mem_size)
         2'b00:   mem_len = 3'd1;
         2'b01:   mem_len = 3'd2;
         default: mem_len = 3'd4;
      endcase
   end

   // RAM data lags its address by one cycle, so edge Ek captures byte k-2.
   always_comb begin
      rbuf_next = rbuf;
      case (edge_k)
         3'd2:    rbuf_next[7:0]   = ram_din;
         3'd3:    rbuf_next[15:8]  = ram_din;
         3'd4:    rbuf_next[23:16] = ram_din;
         3'd5:    rbuf_next[31:24] = ram_din;
         default: rbuf_next = rbuf;
      endcase
   end

   always_comb begin
      wbyte = wdata_q[7:0];
      case (edge_k[1:0])
         2'd1:    wbyte = wdata_q[15:8];
         2'd2:    wbyte = wdata_q[23:16];
         2'd3:    wbyte = wdata_q[31:24];
         default: wbyte = wdata_q[7:0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= OWN_IF;
         base_addr <= '0;
         len       <= 3'd0;
         cnt       <= 3'd0;
         wdata_q   <= 32'h0;
         rbuf      <= 32'h0;
         wr_q      <= 1'b0;
         ram_a     <= '0;
         ram_dout  <= 8'h00;
         if_done   <= 1'b0;
         if_data   <= 32'h0;
         mem_done  <= 1'b0;
         mem_rdata <= 32'h0;
      end else if (rdy) begin
         case (state)
            IDLE: begin
               cnt  <= 3'd0;
               rbuf <= 32'h0;
               wr_q <= 1'b0;
               if (mem_req) begin
                  owner     <= OWN_MEM;
                  base_addr <= mem_addr;
                  len       <= mem_len;
                  wdata_q   <= mem_wdata;
                  ram_a     <= mem_addr;
                  if (mem_we) begin
                     state    <= WRITE;
                     ram_dout <= mem_wdata[7:0];
                     wr_q     <= 1'b1;
                  end else begin
                     state <= READ;
                  end
               end else if (if_req) begin
                  owner     <= OWN_IF;
                  base_addr <= if_addr;
                  len       <= 3'd4;
                  ram_a     <= if_addr;
                  state     <= READ;
               end
            end
            READ: begin
               if (owner == OWN_IF && if_abort) begin
                  state <= IDLE;
               end else begin
                  if (edge_k < len)
                     ram_a <= next_addr;
                  rbuf <= rbuf_next;
                  cnt  <= edge_k;
                  if (edge_k == len + 3'd1) begin
                     state <= DONE;
                     if (owner == OWN_IF) begin
                        if_done <= 1'b1;
                        if_data <= rbuf_next;
                     end else begin
                        mem_done  <= 1'b1;
                        mem_rdata <= rbuf_next;
                     end
                  end
               end
            end
            WRITE: begin
               cnt <= edge_k;
               if (edge_k < len) begin
                  ram_a    <= next_addr;
                  ram_dout <= wbyte;
               end else begin
                  wr_q     <= 1'b0;
                  state    <= DONE;
                  mem_done <= 1'b1;
               end
            end
            DONE: begin
               if_done  <= 1'b0;
               mem_done <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model and done-data scoreboards.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_abort;
   logic        if_done;
   logic [31:0] if_data;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic [7:0]  ram_din = 8'h00;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;

   logic [7:0]  ram [0:65535];
   logic [31:0] if_q[$];
   logic [32:0] mem_q[$];
   int          compared = 0;
   int          mismatched = 0;

   mem_arbiter #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
      .if_done(if_done), .if_data(if_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: read data appears the cycle after the address is sampled.
   always @(posedge clk) begin
      if (ram_wr === 1'b1)
         ram[ram_a[15:0]] <= ram_dout;
      ram_din <= ram[ram_a[15:0]];
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Done pulses pop the scoreboard; a done with nothing expected is itself an error.
   always @(posedge clk) begin
      #1;
      if (rst === 1'b0 && if_done === 1'b1) begin
         if (if_q.size() == 0)
            check_output("if_spurious_done", {31'h0, if_done}, 32'h0);
         else
            check_output("if_data", if_data, if_q.pop_front());
      end
      if (rst === 1'b0 && mem_done === 1'b1) begin
         if (mem_q.size() == 0) begin
            check_output("mem_spurious_done", {31'h0, mem_done}, 32'h0);
         end else begin
            logic [32:0] e;
            e = mem_q.pop_front();
            if (e[32])
               check_output("mem_rdata", mem_rdata, e[31:0]);
         end
      end
   end

   task automatic wait_if_done();
      int n = 0;
      while (if_done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check_output("if_done_timeout", {31'h0, if_done}, 32'h1);
   endtask

   task automatic wait_mem_done();
      int n = 0;
      while (mem_done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check_output("mem_done_timeout", {31'h0, mem_done}, 32'h1);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++)
         ram[i] <= 8'h00;
      #0;
      ram[16'h1000] <= 8'h13; ram[16'h1001] <= 8'h05;
      ram[16'h2000] <= 8'h11; ram[16'h2001] <= 8'h22;
      ram[16'h2002] <= 8'h33; ram[16'h2003] <= 8'h44;
      ram[16'h0020] <= 8'hAB;
      ram[16'hFFFF] <= 8'h34; ram[16'h0000] <= 8'h12;

      rst = 1'b1; rdy = 1'b1;
      if_req = 0; if_addr = 0; if_abort = 0;
      mem_req = 0; mem_we = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
      #12;
      check_output("rst_ram_a", ram_a, 32'h0);
      check_output("rst_outs", {28'h0, if_done, mem_done, ram_wr, |ram_dout}, 32'h0);
      check_output("rst_data", if_data | mem_rdata, 32'h0);
      @(negedge clk); rst = 1'b0;
      tick();

      // Word fetch at 0x1000
      if_req = 1; if_addr = 32'h1000;
      if_q.push_back(32'h0000_0513);
      tick(); check_output("wf_a0", ram_a, 32'h1000);
      check_output("wf_wr", {31'h0, ram_wr}, 32'h0);
      tick(); check_output("wf_a1", ram_a, 32'h1001);
      tick(); check_output("wf_a2", ram_a, 32'h1002);
      tick(); check_output("wf_a3", ram_a, 32'h1003);
      tick(); check_output("wf_e4_done", {31'h0, if_done}, 32'h0);
      tick(); check_output("wf_e5_done", {31'h0, if_done}, 32'h1);
      if_req = 0;
      tick(); check_output("wf_e6_done", {31'h0, if_done}, 32'h0);

      // Simultaneous requests: MEM byte load wins
      mem_req = 1; mem_we = 0; mem_size = 2'b00; mem_addr = 32'h20;
      if_req = 1; if_addr = 32'h2000;
      mem_q.push_back({1'b1, 32'h0000_00AB});
      if_q.push_back(32'h4433_2211);
      tick(); check_output("sim_a0", ram_a, 32'h20);
      tick(); check_output("sim_e1_done", {31'h0, mem_done}, 32'h0);
      tick(); check_output("sim_e2_done", {31'h0, mem_done}, 32'h1);
      mem_req = 0;
      tick(); check_output("sim_e3_done", {31'h0, mem_done}, 32'h0);
      check_output("sim_e3_a", ram_a, 32'h20);
      tick(); check_output("sim_if_grant", ram_a, 32'h2000);
      wait_if_done();
      if_req = 0;
      tick();

      // Word store
      mem_req = 1; mem_we = 1; mem_size = 2'b10; mem_addr = 32'h30; mem_wdata = 32'hDEADBEEF;
      mem_q.push_back({1'b0, 32'h0});
      for (int k = 0; k < 4; k++) begin
         logic [31:0] wd;
         wd = 32'hDEADBEEF;
         tick();
         check_output("st_wr", {31'h0, ram_wr}, 32'h1);
         check_output("st_a", ram_a, 32'h30 + 32'(k));
         check_output("st_dout", {24'h0, ram_dout}, {24'h0, wd[8*k +: 8]});
      end
      tick(); check_output("st_e4_done", {31'h0, mem_done}, 32'h1);
      check_output("st_e4_wr", {31'h0, ram_wr}, 32'h0);
      mem_req = 0;
      tick(); check_output("st_e5_wr", {31'h0, ram_wr}, 32'h0);
      check_output("st_ram", {ram[16'h33], ram[16'h32], ram[16'h31], ram[16'h30]}, 32'hDEADBEEF);

      // Abort at E2, then a fresh fetch from IDLE
      if_req = 1; if_addr = 32'h1000;
      tick(); tick();
      if_abort = 1; if_req = 0;
      tick();
      check_output("ab_done", {31'h0, if_done}, 32'h0);
      if_abort = 0; if_req = 1; if_addr = 32'h2000;
      if_q.push_back(32'h4433_2211);
      tick(); check_output("ab_regrant", ram_a, 32'h2000);
      wait_if_done();
      if_req = 0;
      tick();

      // rdy stall during a store, after byte 1
      mem_req = 1; mem_we = 1; mem_size = 2'b10; mem_addr = 32'h40; mem_wdata = 32'h04030201;
      mem_q.push_back({1'b0, 32'h0});
      tick(); tick();
      check_output("stl_a1", ram_a, 32'h41);
      rdy = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check_output("stl_wr", {31'h0, ram_wr}, 32'h0);
         check_output("stl_a", ram_a, 32'h41);
         tick();
      end
      rdy = 1;
      #1;
      check_output("stl_resume_wr", {31'h0, ram_wr}, 32'h1);
      tick(); check_output("stl_a2", ram_a, 32'h42);
      tick(); check_output("stl_a3", ram_a, 32'h43);
      check_output("stl_e6_done", {31'h0, mem_done}, 32'h0);
      tick(); check_output("stl_e7_done", {31'h0, mem_done}, 32'h1);
      mem_req = 0;
      tick();
      check_output("stl_ram", {ram[16'h43], ram[16'h42], ram[16'h41], ram[16'h40]}, 32'h04030201);

      // Half-word load wrapping past the top of the address space
      mem_req = 1; mem_we = 0; mem_size = 2'b01; mem_addr = 32'hFFFF_FFFF;
      mem_q.push_back({1'b1, 32'h0000_1234});
      tick(); check_output("wr_a0", ram_a, 32'hFFFF_FFFF);
      tick(); check_output("wr_a1", ram_a, 32'h0000_0000);
      wait_mem_done();
      mem_req = 0;
      tick();

      // Reset mid-store
      mem_req = 1; mem_we = 1; mem_size = 2'b10; mem_addr = 32'h50; mem_wdata = 32'hCAFEF00D;
      tick(); tick(); tick();
      check_output("rs_pre_wr", {31'h0, ram_wr}, 32'h1);
      #2 rst = 1;
      #1;
      check_output("rs_ram_wr", {31'h0, ram_wr}, 32'h0);
      check_output("rs_ram_a", ram_a, 32'h0);
      check_output("rs_dout", {24'h0, ram_dout}, 32'h0);
      check_output("rs_done", {30'h0, if_done, mem_done}, 32'h0);
      mem_req = 0;
      #3 rst = 0;
      for (int i = 0; i < 6; i++) tick();
      check_output("rs_no_done", {31'h0, mem_done}, 32'h0);

      check_output("if_q_left", 32'(if_q.size()), 32'h0);
      check_output("mem_q_left", 32'(mem_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
